// File: rtl/pulse_mon_pkg.sv
// Shared definitions for the pulse sequence monitor.
//   state_e   : monitor FSM states (IDLE, ARMED, PULSED)
//   err_t     : 3-bit error code type and its named codes
//   err_merge : first-error-wins capture of the error code
package pulse_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_PULSED = 2'b10
    } state_e;

    typedef logic [2:0] err_t;

    localparam err_t ERR_NONE     = 3'b000;
    localparam err_t ERR_NO_ARM   = 3'b001;
    localparam err_t ERR_NO_PULSE = 3'b010;
    localparam err_t ERR_DOUBLE   = 3'b011;
    localparam err_t ERR_TIMEOUT  = 3'b100;

    // Once an error is held it is never replaced; otherwise a new event is captured.
    function automatic err_t err_merge(input logic held_valid, input err_t held, input err_t evt);
        err_t res;
        if (held_valid) begin
            res = held;
        end else if (evt != ERR_NONE) begin
            res = evt;
        end else begin
            res = held;
        end
        return res;
    endfunction

endpackage

// File: rtl/pulse_mon_sat_cnt.sv
// Saturating up-counter: counts inc strobes, sticks at all-ones, clr wins.
// Ports:
//   clk  : system clock (rising edge)
//   rstn : asynchronous active-low reset
//   clr  : synchronous clear to zero (priority over inc)
//   inc  : increment request
//   cnt  : registered count value
module pulse_mon_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    assign cnt = cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/pulse_seq_monitor.sv
// Watches an upstream FSM's ABOUT_TO_PULSE / COMB_PULSE / LEAVING indications
// and checks they follow arm -> pulse -> leave. Valid pulses are counted
// (saturating), a complete sequence strobes done_pulse, and the first protocol
// violation is latched in seq_err / err_code until clr.
// Optional feature macro: PULSE_MON_TIMEOUT_EN enables an ARMED-state watchdog
// of TIMEOUT_CYC cycles (error code 100); without it ARMED waits forever.
// Ports:
//   clk, rstn        : clock (rising edge), asynchronous active-low reset
//   about_to_pulse   : arm indication
//   comb_pulse       : pulse indication
//   leaving          : exit indication
//   clr              : synchronous clear of count, errors and state
//   pulse_cnt        : saturating count of valid pulses
//   done_pulse       : one-cycle strobe per valid arm-pulse-leave sequence
//   busy             : state is not IDLE
//   seq_err          : sticky error flag
//   err_code         : code of the first captured error
module pulse_seq_monitor
    import pulse_mon_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             about_to_pulse,
    input  logic             comb_pulse,
    input  logic             leaving,
    input  logic             clr,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             done_pulse,
    output logic             busy,
    output logic             seq_err,
    output logic [2:0]       err_code
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
        $error("pulse_seq_monitor: TIMEOUT_CYC must be at least 1");
    end

    state_e state_r;
    state_e state_nxt_s;
    logic   done_nxt_s;
    logic   inc_s;
    err_t   err_evt_s;
    logic   tmo_s;
    logic   done_r;
    logic   busy_r;
    logic   seq_err_r;
    err_t   err_code_r;

`ifdef PULSE_MON_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] tmr_r;

    // Fires on the last allowed ARMED cycle without a pulse.
    assign tmo_s = (tmr_r == TMR_W'(TIMEOUT_CYC - 1));

    // Consecutive-ARMED-cycle timer; restarts whenever ARMED is entered or left.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmr_r <= {TMR_W{1'b0}};
        end else if (clr || (state_nxt_s != ST_ARMED) || (state_r != ST_ARMED)) begin
            tmr_r <= {TMR_W{1'b0}};
        end else begin
            tmr_r <= tmr_r + TMR_W'(1'b1);
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    // Next-state, count-increment, completion and error-event decode.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        inc_s       = 1'b0;
        err_evt_s   = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (about_to_pulse) begin
                    state_nxt_s = ST_ARMED;
                end else if (comb_pulse) begin
                    err_evt_s = ERR_NO_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (comb_pulse) begin
                    inc_s = 1'b1;
                    if (leaving) begin
                        // Pulse and leave together completes the sequence at once.
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PULSED;
                    end
                end else if (leaving) begin
                    state_nxt_s = ST_IDLE;
                    err_evt_s   = ERR_NO_PULSE;
                end else if (tmo_s) begin
                    state_nxt_s = ST_IDLE;
                    err_evt_s   = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_PULSED: begin
                if (comb_pulse) begin
                    // A second pulse poisons the sequence: no count, no done.
                    err_evt_s = ERR_DOUBLE;
                    if (leaving) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PULSED;
                    end
                end else if (leaving) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PULSED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; clr overrides every same-cycle event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            seq_err_r  <= 1'b0;
            err_code_r <= ERR_NONE;
        end else if (clr) begin
            state_r    <= ST_IDLE;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            seq_err_r  <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            state_r    <= state_nxt_s;
            done_r     <= done_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            seq_err_r  <= seq_err_r | (err_evt_s != ERR_NONE);
            err_code_r <= err_merge(seq_err_r, err_code_r, err_evt_s);
        end
    end

    pulse_mon_sat_cnt #(
        .W (CNT_W)
    ) u_sat_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (inc_s & ~clr),
        .cnt  (pulse_cnt)
    );

    assign done_pulse = done_r;
    assign busy       = busy_r;
    assign seq_err    = seq_err_r;
    assign err_code   = err_code_r;

endmodule

// File: doc/pulse_seq_monitor.md
PULSE_SEQ_MONITOR -- requirements
Module: pulse_seq_monitor

Interface
REQ-001 Parameter CNT_W, default 8, width of the pulse counter.
REQ-002 Parameter TIMEOUT_CYC, default 16, ARMED-state watchdog limit in cycles (used only with PULSE_MON_TIMEOUT_EN).
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 about_to_pulse  input  1  upstream FSM arm indication (ABOUT_TO_PULSE).
REQ-006 comb_pulse  input  1  upstream FSM pulse (COMB_PULSE).
REQ-007 leaving  input  1  upstream FSM exit indication (LEAVING).
REQ-008 clr  input  1  synchronous clear of count, errors and state.
REQ-009 pulse_cnt  output  CNT_W  count of valid pulses, saturating.
REQ-010 done_pulse  output  1  one-cycle strobe on a valid arm-pulse-leave sequence.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 seq_err  output  1  sticky error flag.
REQ-013 err_code  output  3  first error captured: 000 none, 001 pulse without arm, 010 leave without pulse, 011 double pulse, 100 timeout.

Function
REQ-014 The block SHALL implement FSM states IDLE, ARMED and PULSED; all outputs SHALL be registered, updating one cycle after the sampling edge.
REQ-015 IDLE: about_to_pulse -> ARMED; comb_pulse without about_to_pulse -> error 001, stay in IDLE, no count; leaving alone -> ignored.
REQ-016 ARMED: comb_pulse -> PULSED and pulse_cnt+1; leaving without comb_pulse -> IDLE and error 010; about_to_pulse held high -> stay in ARMED, no error.
REQ-017 ARMED with comb_pulse and leaving in the same cycle: pulse_cnt+1, done_pulse=1, next state IDLE, no error.
REQ-018 PULSED: leaving -> IDLE with done_pulse=1 for exactly one cycle; comb_pulse -> error 011, no count, stay in PULSED; comb_pulse and leaving together -> error 011, done_pulse=0, next state IDLE.
REQ-019 pulse_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-020 seq_err SHALL set on the first error and hold; err_code SHALL hold the first error's code, and later errors SHALL NOT overwrite it until clr.
REQ-021 clr SHALL have priority over all same-cycle events: next cycle state=IDLE, pulse_cnt=0, seq_err=0, err_code=000, done_pulse=0.

Reset
REQ-022 rstn low SHALL asynchronously force state=IDLE, pulse_cnt=0, done_pulse=0, busy=0, seq_err=0, err_code=000.
REQ-023 Reset mid-sequence SHALL discard the sequence without flagging an error; the first post-reset comb_pulse without an arm SHALL flag 001.

Configuration
REQ-024 With PULSE_MON_TIMEOUT_EN defined, a cycle counter SHALL run in ARMED; after TIMEOUT_CYC consecutive ARMED cycles without comb_pulse, the FSM SHALL go to IDLE and flag error 100.
REQ-025 With PULSE_MON_TIMEOUT_EN undefined, no timer SHALL be built, ARMED SHALL wait indefinitely, and code 100 SHALL never occur.

Structure
REQ-026 Package pulse_mon_pkg SHALL hold the state enum typedef and the err_code constants (ERR_NONE, ERR_NO_ARM, ERR_NO_PULSE, ERR_DOUBLE, ERR_TIMEOUT).
REQ-027 Sub-module pulse_mon_sat_cnt, a parameterised saturating counter with inc and clr, SHALL implement pulse_cnt; the FSM SHALL stay in the top module.

Verification
REQ-028 Normal sequence: arm, then pulse one cycle later, then leave one cycle later, repeated 3 times -> pulse_cnt=3, three done_pulse strobes, seq_err=0.
REQ-029 comb_pulse in IDLE, then leaving in ARMED with no pulse -> seq_err=1, err_code=001 (second error not captured), pulse_cnt=0.
REQ-030 Saturation: CNT_W=2, 5 valid sequences -> pulse_cnt=3; then clr together with comb_pulse -> pulse_cnt=0, state=IDLE.
REQ-031 Simultaneous events: comb_pulse and leaving together in ARMED -> pulse_cnt+1, single done_pulse, busy=0 next cycle; repeated in PULSED -> err_code=011, no count.
REQ-032 rstn asserted while in PULSED, released, then leaving -> all outputs 0, no done_pulse, no error.
REQ-033 With PULSE_MON_TIMEOUT_EN and TIMEOUT_CYC=16, arm then hold ARMED for 16 cycles -> err_code=100, busy=0; without the macro -> busy stays 1, seq_err=0.
